period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter N, default 22: width of the cycle counter and of the measurement outputs; legal range 4..32.
REQ-002 SHALL have clk_in  input  1: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have sig_in  input  1: slow, asynchronous signal under measurement (e.g. a prescaler clk_out).
REQ-005 SHALL have period  output  N: clk_in cycles between the last two sig_in rising edges.
REQ-006 SHALL have high_time  output  N: clk_in cycles sig_in was high within that period.
REQ-007 SHALL have valid  output  1: one-cycle pulse; period, high_time and ovf are updated on this cycle.
REQ-008 SHALL have ovf  output  1: the reported period reached saturation (2^N-1).
REQ-009 SHALL have busy  output  1: high in state MEASURE.

Function
REQ-010 SHALL pass sig_in through a 2-flop synchronizer (s1, s2), then a third flop s3, before use.
REQ-011 SHALL detect a rise when s2=1 and s3=0, and a fall when s2=0 and s3=1.
REQ-012 SHALL implement states IDLE and MEASURE.
REQ-013 IDLE: counter held at 0; a fall is ignored; a rise -> MEASURE with cnt cleared to 0 and no valid pulse.
REQ-014 MEASURE: cnt increments by 1 every cycle with no rise, saturating at 2^N-1 (it never wraps).
REQ-015 MEASURE on a fall: hi_lat <= cnt+1, saturating at 2^N-1.
REQ-016 MEASURE on a rise: period <= cnt+1 (saturating), high_time <= hi_lat, ovf <= (cnt = 2^N-1), valid <= 1, cnt <= 0; stay in MEASURE.
REQ-017 For a periodic sig_in of P cycles with H cycles high (P < 2^N-1), period = P and high_time = H.
REQ-018 Latency: if s1 first samples 1 at clk_in edge k, the valid pulse is high in the cycle following edge k+2.
REQ-019 valid SHALL be high for exactly one cycle per measured rise and low otherwise.
REQ-020 period, high_time and ovf SHALL hold their values between valid pulses.
REQ-021 Saturation: once cnt = 2^N-1 it holds; the next rise reports period = 2^N-1 and ovf = 1, and measurement continues normally.
REQ-022 Simultaneous rise and saturation in the same cycle: the rise takes priority, with ovf taken from the pre-increment cnt.
REQ-023 If no fall was seen since the previous rise, high_time SHALL report the stale hi_lat (not possible for a synchronized signal; documented only).

Reset
REQ-024 On rst=1 at a clock edge: state <= IDLE; cnt, hi_lat, period and high_time <= 0; valid, ovf and busy <= 0; s1, s2 and s3 <= 0.
REQ-025 Reset SHALL override all other events in the same cycle.
REQ-026 Reset mid-measurement discards the partial count; the first rise after reset only arms the block (no valid).
REQ-027 The same initial values SHALL apply at configuration, for boards without a reset driver.

Structure
REQ-028 SHALL contain one sub-module sync_edge: the 2-flop synchronizer plus the edge register, with outputs level, rise and fall.
REQ-029 No shared package: the state encoding and the saturation constant {N{1'b1}} are local constants.
REQ-030 The file SHALL carry an include guard, as for the other single-file blocks.

Verification
REQ-031 Drive a square wave with P=8, H=4, N=22 -> first valid on the 2nd synchronized rise; period=8, high_time=4, ovf=0; one valid every 8 cycles thereafter.
REQ-032 Feed sig_in from a prescaler instance with N=4 on the same clk_in -> period=16, high_time=8 on every valid.
REQ-033 Use N=4 with sig_in held low for 40 cycles after arming, then a rise -> valid with period=15, ovf=1; the next 8-cycle period reports period=8, ovf=0.
REQ-034 Assert rst for 1 cycle 3 cycles into a P=10 measurement -> all outputs 0; the next rise gives no valid; the following rise gives period=10.
REQ-035 Rise sampled by s1 at edge k -> valid high only in the cycle following edge k+2, and low in every other cycle.
REQ-036 Use a duty-cycle sweep at P=12 with H=1..11 -> high_time=H and period=12 each time.

Source files
------------

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus an edge register,
// giving a clean level and single-cycle rise/fall strobes in the clk_in domain.
`ifndef PERIOD_METER_SYNC_EDGE_SV
`define PERIOD_METER_SYNC_EDGE_SV

module sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // Power-up values match reset so boards without a reset driver start clean.
  logic r_s1 = 1'b0;
  logic r_s2 = 1'b0;
  logic r_s3 = 1'b0;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign level = r_s2;
  assign rise  = r_s2 & ~r_s3;
  assign fall  = ~r_s2 & r_s3;

endmodule

`endif

// File: rtl/period_meter.sv
// Measures the period and high time of a slow asynchronous signal in clk_in
// cycles, with a saturating counter and an overflow flag on the reported period.
`ifndef PERIOD_METER_SV
`define PERIOD_METER_SV

module period_meter #(
  parameter int unsigned N = 22
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         ovf,
  output logic         busy
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam logic [N-1:0] SAT = {N{1'b1}};
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
    return (v == SAT) ? SAT : v + ONE;
  endfunction

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_unused_level;

  sync_edge u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .level  (w_level),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  assign w_unused_level = w_level;

  state_t       r_state  = ST_IDLE;
  logic [N-1:0] r_cnt    = '0;
  logic [N-1:0] r_hi_lat = '0;
  logic [N-1:0] r_period = '0;
  logic [N-1:0] r_high   = '0;
  logic         r_valid  = 1'b0;
  logic         r_ovf    = 1'b0;

  state_t       w_state_nx;
  logic [N-1:0] w_cnt_nx;
  logic [N-1:0] w_hi_lat_nx;
  logic [N-1:0] w_period_nx;
  logic [N-1:0] w_high_nx;
  logic         w_valid_nx;
  logic         w_ovf_nx;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_hi_lat_nx = r_hi_lat;
    w_period_nx = r_period;
    w_high_nx   = r_high;
    w_valid_nx  = 1'b0;
    w_ovf_nx    = r_ovf;
    case (r_state)
      ST_IDLE: begin
        // First rise only arms the meter; there is no previous edge to measure from.
        w_cnt_nx = '0;
        if (w_rise) w_state_nx = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_rise) begin
          // Rise wins over saturation; ovf reflects the count before any increment.
          w_period_nx = sat_inc(r_cnt);
          w_high_nx   = r_hi_lat;
          w_ovf_nx    = (r_cnt == SAT);
          w_valid_nx  = 1'b1;
          w_cnt_nx    = '0;
        end else begin
          w_cnt_nx = sat_inc(r_cnt);
          if (w_fall) w_hi_lat_nx = sat_inc(r_cnt);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi_lat <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_hi_lat <= w_hi_lat_nx;
      r_period <= w_period_nx;
      r_high   <= w_high_nx;
      r_valid  <= w_valid_nx;
      r_ovf    <= w_ovf_nx;
    end
  end

  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = r_valid;
  assign ovf       = r_ovf;
  assign busy      = (r_state == ST_MEASURE);

endmodule

`endif

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: N=22 and N=4 instances driven by hand-built
// waveforms, plus an N=22 instance fed from a free-running divide-by-16 counter.
module tb_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst22, rst4, rst_ps;
  logic        s22, s4, sps;
  logic [21:0] p22, h22, pps, hps;
  logic [3:0]  p4, h4;
  logic        v22, o22, b22, v4, o4, b4, vps, ops, bps;
  logic [3:0]  ps_cnt;

  period_meter #(.N(22)) dut22 (
    .clk_in(clk), .rst(rst22), .sig_in(s22), .period(p22), .high_time(h22),
    .valid(v22), .ovf(o22), .busy(b22));

  period_meter #(.N(4)) dut4 (
    .clk_in(clk), .rst(rst4), .sig_in(s4), .period(p4), .high_time(h4),
    .valid(v4), .ovf(o4), .busy(b4));

  period_meter #(.N(22)) dutps (
    .clk_in(clk), .rst(rst_ps), .sig_in(sps), .period(pps), .high_time(hps),
    .valid(vps), .ovf(ops), .busy(bps));

  // Divide-by-16 prescaler: output low 8 cycles, high 8 cycles.
  always_ff @(posedge clk) begin
    if (rst_ps) ps_cnt <= 4'd0;
    else        ps_cnt <= ps_cnt + 4'd1;
  end
  assign sps = ps_cnt[3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nv22 = 0, t22 = 0, pt22 = 0, nv4 = 0, nvps = 0, nv_base = 0;
  logic [21:0] lp22, lh22;
  logic [3:0]  lp4, lh4;
  logic        lo4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (v22) begin
      nv22++; pt22 = t22; t22 = cyc; lp22 = p22; lh22 = h22;
    end
    if (v4) begin
      nv4++; lp4 = p4; lh4 = h4; lo4 = o4;
    end
    if (vps) begin
      nvps++;
      chk("ps_period", pps, 16);
      chk("ps_high", hps, 8);
      chk("ps_ovf", ops, 0);
    end
  endtask

  task automatic set_sig(input int sel, input logic val);
    if (sel == 0) s22 = val;
    else          s4 = val;
  endtask

  task automatic wave(input int sel, input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      set_sig(sel, 1'b1);
      repeat (h) tick();
      set_sig(sel, 1'b0);
      repeat (p - h) tick();
    end
  endtask

  initial begin
    rst22 = 1'b1; rst4 = 1'b1; rst_ps = 1'b1;
    s22 = 1'b0; s4 = 1'b0;
    repeat (2) tick();
    chk("rst_period", p22, 0);
    chk("rst_high", h22, 0);
    chk("rst_valid", v22, 0);
    chk("rst_ovf", o22, 0);
    chk("rst_busy", b22, 0);
    chk("rst_period4", p4, 0);
    rst22 = 1'b0; rst4 = 1'b0; rst_ps = 1'b0;
    tick();

    // P=8, H=4: first rise arms only
    wave(0, 8, 4, 1);
    chk("arm_no_valid", nv22, 0);
    chk("arm_busy", b22, 1);

    // second rise: valid exactly in the cycle after edge k+2
    s22 = 1'b1;
    tick(); chk("lat_k", v22, 0);
    tick(); chk("lat_k1", v22, 0);
    tick(); chk("lat_k2", v22, 1);
    chk("p8_period", p22, 8);
    chk("p8_high", h22, 4);
    chk("p8_ovf", o22, 0);
    tick(); chk("lat_after", v22, 0);
    s22 = 1'b0;
    repeat (4) tick();

    nv_base = nv22;
    wave(0, 8, 4, 3);
    chk("p8_count", nv22 - nv_base, 3);
    chk("p8_spacing", t22 - pt22, 8);
    chk("p8_last_period", lp22, 8);
    chk("p8_last_high", lh22, 4);

    // duty-cycle sweep at P=12
    for (int h = 1; h <= 11; h++) begin
      wave(0, 12, h, 2);
      chk("sweep_period", lp22, 12);
      chk("sweep_high", lh22, h);
    end

    // reset three cycles into a P=10, H=2 measurement
    s22 = 1'b1;
    tick(); tick();
    s22 = 1'b0;
    tick();
    rst22 = 1'b1;
    tick();
    rst22 = 1'b0;
    chk("mid_rst_period", p22, 0);
    chk("mid_rst_high", h22, 0);
    chk("mid_rst_valid", v22, 0);
    chk("mid_rst_ovf", o22, 0);
    chk("mid_rst_busy", b22, 0);
    nv_base = nv22;
    repeat (6) tick();
    wave(0, 10, 2, 1);
    chk("post_rst_arm", nv22, nv_base);
    chk("post_rst_busy", b22, 1);
    wave(0, 10, 2, 1);
    chk("post_rst_count", nv22, nv_base + 1);
    chk("post_rst_period", lp22, 10);
    chk("post_rst_high", lh22, 2);

    // N=4 saturation: arm, hold low for 40 cycles, then rise
    s4 = 1'b1;
    repeat (4) tick();
    s4 = 1'b0;
    repeat (36) tick();
    chk("sat_arm", nv4, 0);
    wave(1, 8, 4, 1);
    chk("sat_count", nv4, 1);
    chk("sat_period", lp4, 15);
    chk("sat_ovf", lo4, 1);
    chk("sat_high", lh4, 4);
    wave(1, 8, 4, 1);
    chk("after_sat_count", nv4, 2);
    chk("after_sat_period", lp4, 8);
    chk("after_sat_ovf", lo4, 0);
    chk("after_sat_high", lh4, 4);
    repeat (5) tick();
    chk("hold_period4", p4, 8);
    chk("hold_high4", h4, 4);
    chk("hold_valid4", v4, 0);

    chk("ps_valids", (nvps >= 10) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
